// File: rtl/conv2d_pkg.sv
// Shared types and constants for the conv2d layer scheduler: FSM state encoding,
// default counter widths and the PE command indices.
package conv2d_pkg;

    localparam int CH_W_DEFAULT  = 8;
    localparam int ROW_W_DEFAULT = 8;

    localparam int NUM_CMDS  = 4;
    localparam int CMD_IDX_W = 2;

    localparam logic [CMD_IDX_W-1:0] CMD_LOAD_K      = 2'd0;
    localparam logic [CMD_IDX_W-1:0] CMD_STREAM_MID  = 2'd1;
    localparam logic [CMD_IDX_W-1:0] CMD_STREAM_LAST = 2'd2;
    localparam logic [CMD_IDX_W-1:0] CMD_LAST_CH     = 2'd3;

    typedef enum logic [3:0] {
        S_IDLE,
        S_SET_LAST,
        S_LOAD_K,
        S_WAIT_READY,
        S_WAIT_ROW,
        S_WAIT_MID,
        S_WAIT_LAST,
        S_NEXT_CH,
        S_DONE
    } state_t;

endpackage

// File: rtl/conv2d_cmd_issuer.sv
// Turns a pending command request into a registered one-cycle PE command,
// issued only when the PE with its buffers reports idle.
module conv2d_cmd_issuer
    import conv2d_pkg::*;
(
    input  logic                 clk,
    input  logic                 Reset,
    input  logic                 pe_idle,
    input  logic                 req_valid,
    input  logic [CMD_IDX_W-1:0] req_idx,
    output logic                 fire,
    output logic [NUM_CMDS-1:0]  cmd
);

    // The FSM advances on fire, so the pulse lands exactly one cycle later.
    assign fire = req_valid && pe_idle;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (Reset) begin
            cmd <= '0;
        end else begin
            cmd <= '0;
            if (fire) begin
                cmd[req_idx] <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/conv2d_layer_scheduler.sv
// Sequences one conv2d layer: per input channel a kernel load, then one stream
// command per row, with the last-channel flag raised before the final channel.
module conv2d_layer_scheduler
    import conv2d_pkg::*;
#(
    parameter int CH_W  = CH_W_DEFAULT,
    parameter int ROW_W = ROW_W_DEFAULT
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             start,
    input  logic [CH_W-1:0]  cfg_num_in_channels,
    input  logic [ROW_W-1:0] cfg_num_rows,
    input  logic             row_buf_valid,
    input  logic             PE_with_buffers_IDLE,
    input  logic             PE_ready,
    input  logic             Done_1row,
    output logic             Load_kernel_reg,
    output logic             Stream_mid_row,
    output logic             Stream_last_row,
    output logic             last_channel,
    output logic [CH_W-1:0]  b_counter_output,
    output logic [ROW_W-1:0] row_counter_out,
    output logic             row_consume,
    output logic             busy,
    output logic             done,
    output logic             cfg_err
);

    state_t               state, state_n;
    logic [CH_W-1:0]      num_ch_q;
    logic [ROW_W-1:0]     num_rows_q;
    logic [CH_W-1:0]      last_ch_idx;
    logic [CH_W-1:0]      next_ch_idx;
    logic [ROW_W-1:0]     last_row_idx;
    logic                 cfg_zero;
    logic                 cmd_req;
    logic                 cmd_fire;
    logic [CMD_IDX_W-1:0] cmd_idx;
    logic [NUM_CMDS-1:0]  cmd;

    assign cfg_zero     = (cfg_num_in_channels == '0) || (cfg_num_rows == '0);
    assign last_ch_idx  = num_ch_q - CH_W'(1);
    assign next_ch_idx  = b_counter_output + CH_W'(1);
    assign last_row_idx = num_rows_q - ROW_W'(1);

    conv2d_cmd_issuer u_cmd_issuer (
        .clk       (clk),
        .Reset     (Reset),
        .pe_idle   (PE_with_buffers_IDLE),
        .req_valid (cmd_req),
        .req_idx   (cmd_idx),
        .fire      (cmd_fire),
        .cmd       (cmd)
    );

    assign Load_kernel_reg = cmd[CMD_LOAD_K];
    assign Stream_mid_row  = cmd[CMD_STREAM_MID];
    assign Stream_last_row = cmd[CMD_STREAM_LAST];
    assign last_channel    = cmd[CMD_LAST_CH];
    // The line buffer pops in the same cycle the PE is told to stream a row.
    assign row_consume     = Stream_mid_row || Stream_last_row;

    always_ff @(posedge clk) begin
        if (Reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // NOTE: every combinational output gets a default first so no path
    // through the case statement can infer a latch.
    always_comb begin
        state_n = state;
        cmd_req = 1'b0;
        cmd_idx = CMD_LOAD_K;
        unique case (state)
            S_IDLE: begin
                if (start && !cfg_zero) begin
                    state_n = (cfg_num_in_channels == CH_W'(1)) ? S_SET_LAST : S_LOAD_K;
                end
            end
            S_SET_LAST: begin
                cmd_req = 1'b1;
                cmd_idx = CMD_LAST_CH;
                if (cmd_fire) state_n = S_LOAD_K;
            end
            S_LOAD_K: begin
                cmd_req = 1'b1;
                cmd_idx = CMD_LOAD_K;
                if (cmd_fire) state_n = S_WAIT_READY;
            end
            S_WAIT_READY: begin
                if (PE_ready) state_n = S_WAIT_ROW;
            end
            S_WAIT_ROW: begin
                cmd_req = row_buf_valid;
                if (row_counter_out < last_row_idx) begin
                    cmd_idx = CMD_STREAM_MID;
                    if (cmd_fire) state_n = S_WAIT_MID;
                end else begin
                    cmd_idx = CMD_STREAM_LAST;
                    if (cmd_fire) state_n = S_WAIT_LAST;
                end
            end
            S_WAIT_MID: begin
                if (Done_1row) state_n = S_WAIT_ROW;
            end
            S_WAIT_LAST: begin
                if (Done_1row) state_n = S_NEXT_CH;
            end
            S_NEXT_CH: begin
                if (b_counter_output == last_ch_idx) begin
                    state_n = S_DONE;
                end else begin
                    state_n = (next_ch_idx == last_ch_idx) ? S_SET_LAST : S_LOAD_K;
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            num_ch_q         <= '0;
            num_rows_q       <= '0;
            b_counter_output <= '0;
            row_counter_out  <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            cfg_err          <= 1'b0;
        end else begin
            done    <= 1'b0;
            cfg_err <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        if (cfg_zero) begin
                            cfg_err <= 1'b1;
                        end else begin
                            num_ch_q         <= cfg_num_in_channels;
                            num_rows_q       <= cfg_num_rows;
                            b_counter_output <= '0;
                            row_counter_out  <= '0;
                            busy             <= 1'b1;
                        end
                    end
                end
                S_WAIT_MID: begin
                    if (Done_1row) row_counter_out <= row_counter_out + ROW_W'(1);
                end
                S_NEXT_CH: begin
                    if (b_counter_output != last_ch_idx) begin
                        b_counter_output <= next_ch_idx;
                        row_counter_out  <= '0;
                    end
                end
                S_DONE: begin
                    done <= 1'b1;
                    busy <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv2d_layer_scheduler.sv
// Self-checking bench: a reactive PE/line-buffer stub drives the scheduler and
// every observed command is compared against a per-layer expected command list.
module tb_conv2d_layer_scheduler;
    import conv2d_pkg::*;

    localparam int CH_W  = 8;
    localparam int ROW_W = 8;

    localparam int K_LK   = 0;
    localparam int K_MID  = 1;
    localparam int K_LAST = 2;
    localparam int K_LCH  = 3;

    typedef struct {
        int kind;
        int b;
        int row;
    } exp_cmd_t;

    logic             clk = 1'b0;
    logic             Reset;
    logic             start;
    logic [CH_W-1:0]  cfg_num_in_channels;
    logic [ROW_W-1:0] cfg_num_rows;
    logic             row_buf_valid;
    logic             PE_with_buffers_IDLE;
    logic             PE_ready;
    logic             Done_1row;
    logic             Load_kernel_reg;
    logic             Stream_mid_row;
    logic             Stream_last_row;
    logic             last_channel;
    logic [CH_W-1:0]  b_counter_output;
    logic [ROW_W-1:0] row_counter_out;
    logic             row_consume;
    logic             busy;
    logic             done;
    logic             cfg_err;

    int checks = 0;
    int errors = 0;
    exp_cmd_t exp_q[$];

    conv2d_layer_scheduler #(.CH_W(CH_W), .ROW_W(ROW_W)) dut (
        .clk                  (clk),
        .Reset                (Reset),
        .start                (start),
        .cfg_num_in_channels  (cfg_num_in_channels),
        .cfg_num_rows         (cfg_num_rows),
        .row_buf_valid        (row_buf_valid),
        .PE_with_buffers_IDLE (PE_with_buffers_IDLE),
        .PE_ready             (PE_ready),
        .Done_1row            (Done_1row),
        .Load_kernel_reg      (Load_kernel_reg),
        .Stream_mid_row       (Stream_mid_row),
        .Stream_last_row      (Stream_last_row),
        .last_channel         (last_channel),
        .b_counter_output     (b_counter_output),
        .row_counter_out      (row_counter_out),
        .row_consume          (row_consume),
        .busy                 (busy),
        .done                 (done),
        .cfg_err              (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] all_outputs();
        return {32'd0, Load_kernel_reg, Stream_mid_row, Stream_last_row, last_channel,
                row_consume, busy, done, cfg_err, b_counter_output, row_counter_out};
    endfunction

    // Expected command list for one layer, straight from the layer's loop nest.
    task automatic build_expected(input int ch, input int rows);
        exp_q.delete();
        for (int c = 0; c < ch; c++) begin
            if (c == ch - 1) exp_q.push_back('{K_LCH, c, 0});
            exp_q.push_back('{K_LK, c, 0});
            for (int r = 0; r < rows; r++) begin
                exp_q.push_back('{(r < rows - 1) ? K_MID : K_LAST, c, r});
            end
        end
    endtask

    task automatic reject_cfg(input int ch, input int rows);
        cfg_num_in_channels = CH_W'(ch);
        cfg_num_rows        = ROW_W'(rows);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("cfg_err_pulse", cfg_err, 1);
        check("cfg_err_busy", busy, 0);
        check("cfg_err_no_cmd", {Load_kernel_reg, Stream_mid_row, Stream_last_row, last_channel}, 0);
        tick();
        check("cfg_err_one_cycle", cfg_err, 0);
        check("cfg_err_still_idle", busy, 0);
    endtask

    // rnd: random stub timing; idle_hold/valid_hold: directed stalls; abort_mid1:
    // apply Reset once the layer sits in a mid-row wait of channel 1.
    task automatic run_layer(input int ch, input int rows, input bit rnd,
                             input int idle_hold, input int valid_hold, input bit abort_mid1);
        int s, n, kind_obs, budget;
        int ready_cnt, done_cnt, pready_s, rise_s, release_s, first_cmd, first_stream, n_consume;
        bit ready_pend, done_pend, prev_idle, finished;
        exp_cmd_t e;

        build_expected(ch, rows);
        ready_cnt = 0; done_cnt = 0; ready_pend = 0; done_pend = 0;
        pready_s = -1; rise_s = -1; release_s = -1; first_cmd = -1; first_stream = -1;
        n_consume = 0; finished = 0;
        budget = 40 * ch * (rows + 3) + 100;

        cfg_num_in_channels  = CH_W'(ch);
        cfg_num_rows         = ROW_W'(rows);
        start                = 1'b1;
        PE_with_buffers_IDLE = (idle_hold == 0);
        row_buf_valid        = (valid_hold == 0);
        PE_ready             = 1'b0;
        Done_1row            = 1'b0;
        prev_idle            = PE_with_buffers_IDLE;
        tick();
        start = 1'b0;
        check("busy_on_accept", busy, 1);
        check("b_cnt_on_accept", b_counter_output, 0);
        check("row_cnt_on_accept", row_counter_out, 0);

        s = 1;
        while (!finished && s < budget) begin
            n = int'(Load_kernel_reg) + int'(Stream_mid_row) + int'(Stream_last_row) + int'(last_channel);
            if (n != 0) begin
                check("cmd_onehot", n, 1);
                check("cmd_gated_by_idle", prev_idle, 1);
                if (first_cmd < 0) first_cmd = s;
                kind_obs = Load_kernel_reg ? K_LK : Stream_mid_row ? K_MID : Stream_last_row ? K_LAST : K_LCH;
                if (exp_q.size() == 0) begin
                    check("unexpected_cmd", kind_obs, 99);
                end else begin
                    e = exp_q.pop_front();
                    check("cmd_kind", kind_obs, e.kind);
                    check("cmd_b_counter", b_counter_output, e.b);
                    check("cmd_row_counter", row_counter_out, e.row);
                end
            end
            check("row_consume_with_stream", row_consume, Stream_mid_row | Stream_last_row);
            check("no_cfg_err_while_busy", cfg_err, 0);
            if (row_consume) n_consume++;
            if ((Stream_mid_row || Stream_last_row) && first_stream < 0) first_stream = s;

            if (done) begin
                check("busy_low_at_done", busy, 0);
                check("all_cmds_issued", exp_q.size(), 0);
                check("row_consume_count", n_consume, ch * rows);
                check("final_b_counter", b_counter_output, ch - 1);
                check("final_row_counter", row_counter_out, rows - 1);
                finished = 1;
            end else begin
                check("busy_hold", busy, 1);
            end

            if (!finished && abort_mid1 && Stream_mid_row && b_counter_output == CH_W'(1)) begin
                start = 1'b0; PE_ready = 1'b0; Done_1row = 1'b0;
                Reset = 1'b1;
                tick();
                check("reset_mid_layer_outputs", all_outputs(), 0);
                check("reset_mid_layer_state", dut.state, S_IDLE);
                Reset = 1'b0;
                tick();
                return;
            end

            if (!finished) begin
                // PE stub: answers each command after a delay; spurious pulses
                // only while no answer is owed, so the scheduler must ignore them.
                if (Load_kernel_reg) begin
                    ready_pend = 1;
                    ready_cnt  = rnd ? int'($urandom_range(3, 0)) : 1;
                end
                if (Stream_mid_row || Stream_last_row) begin
                    done_pend = 1;
                    done_cnt  = rnd ? int'($urandom_range(3, 0)) : 1;
                end
                PE_ready = 1'b0;
                if (ready_pend) begin
                    if (ready_cnt == 0) begin
                        PE_ready = 1'b1; ready_pend = 0;
                        if (pready_s < 0) pready_s = s;
                    end else ready_cnt--;
                end else if (rnd && $urandom_range(7, 0) == 0) PE_ready = 1'b1;
                Done_1row = 1'b0;
                if (done_pend) begin
                    if (done_cnt == 0) begin
                        Done_1row = 1'b1; done_pend = 0;
                    end else done_cnt--;
                end else if (rnd && $urandom_range(7, 0) == 0) Done_1row = 1'b1;

                if (idle_hold > 0) begin
                    PE_with_buffers_IDLE = (s > idle_hold);
                    if (s == idle_hold + 1) rise_s = s;
                end else PE_with_buffers_IDLE = rnd ? ($urandom_range(3, 0) != 0) : 1'b1;

                if (valid_hold > 0) begin
                    row_buf_valid = (pready_s >= 0) && (s >= pready_s + valid_hold + 1);
                    if (row_buf_valid && release_s < 0) release_s = s;
                end else row_buf_valid = rnd ? ($urandom_range(1, 0) != 0) : 1'b1;

                if (rnd && $urandom_range(15, 0) == 0) begin
                    start = 1'b1;
                    cfg_num_in_channels = CH_W'($urandom_range(3, 0));
                    cfg_num_rows        = ROW_W'($urandom_range(3, 0));
                end else start = 1'b0;

                prev_idle = PE_with_buffers_IDLE;
                tick();
                s++;
            end
        end

        if (!finished) check("layer_timeout", s, 0);
        if (idle_hold > 0) check("cmd_at_first_idle", first_cmd, rise_s + 1);
        if (valid_hold > 0) check("stream_at_first_valid", first_stream, release_s + 1);

        start = 1'b0; PE_ready = 1'b0; Done_1row = 1'b0;
        PE_with_buffers_IDLE = 1'b1; row_buf_valid = 1'b0;
        tick();
        check("done_one_cycle", done, 0);
        check("b_counter_holds", b_counter_output, ch - 1);
        check("row_counter_holds", row_counter_out, rows - 1);
    endtask

    initial begin
        Reset = 1'b1; start = 1'b0;
        cfg_num_in_channels = '0; cfg_num_rows = '0;
        row_buf_valid = 1'b0; PE_with_buffers_IDLE = 1'b1; PE_ready = 1'b0; Done_1row = 1'b0;
        repeat (3) tick();
        check("reset_outputs", all_outputs(), 0);
        Reset = 1'b0;
        tick();
        check("idle_after_reset", all_outputs(), 0);

        reject_cfg(0, 3);
        reject_cfg(4, 0);
        reject_cfg(0, 0);

        run_layer(2, 3, 0, 0, 0, 0);
        run_layer(1, 1, 0, 0, 0, 0);
        run_layer(2, 2, 0, 0, 20, 0);
        run_layer(3, 2, 0, 5, 0, 0);
        run_layer(2, 3, 0, 0, 0, 1);
        run_layer(2, 3, 0, 0, 0, 0);

        for (int i = 0; i < 12; i++) begin
            run_layer(int'($urandom_range(4, 1)), int'($urandom_range(5, 1)), 1, 0, 0, 0);
        end
        run_layer(255, 1, 1, 0, 0, 0);
        run_layer(1, 255, 1, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
